// File: rtl/bullet_scheduler.sv
// Bullet table for two tanks x 8 slots: spawns on fire, clears on hit,
// and walks one slot per cycle after each frame tick to move or retire it.
module bullet_scheduler #(
    parameter int STEP     = 4,
    parameter int LIFETIME = 31,
    parameter int COOLDOWN = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   frame_tick,
    input  logic [1:0]             fire_req,
    input  logic [1:0][9:0]        tank_x,
    input  logic [1:0][9:0]        tank_y,
    input  logic [1:0][2:0]        turret_dir,
    input  logic                   hit_valid,
    input  logic                   hit_tank,
    input  logic [2:0]             hit_idx,
    output logic [1:0][7:0][31:0]  bullet_array,
    output logic                   busy,
    output logic [1:0]             fire_drop,
    output logic                   tick_overrun
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    localparam logic signed [11:0] ST    = 12'(STEP);
    localparam logic signed [11:0] LIM_W = 12'(SCREEN_W);
    localparam logic signed [11:0] LIM_H = 12'(SCREEN_H);
    localparam logic [4:0]         LIFE5 = 5'(LIFETIME);
    localparam logic [7:0]         CD8   = 8'(COOLDOWN);

    logic [0:0]            state_q, state_d;
    logic [3:0]            k_q, k_d;
    logic [1:0][7:0]       cd_q, cd_d;
    logic [1:0]            pend_q, pend_d;
    logic [1:0]            drop_q, drop_d;
    logic                  ovr_q, ovr_d;
    logic [1:0][7:0][31:0] tab_q, tab_d;

    logic [1:0]            free_ok;
    logic [1:0][2:0]       free_idx;
    logic                  sw_vld;
    logic [2:0]            sw_dir;
    logic [4:0]            sw_life;
    logic [9:0]            sw_x, sw_y;
    logic signed [11:0]    nx, ny;
    logic                  retire;

    function automatic logic signed [11:0] delta_x(input logic [2:0] d);
        unique case (d)
            3'd1, 3'd2, 3'd3: delta_x = ST;
            3'd5, 3'd6, 3'd7: delta_x = -ST;
            default:          delta_x = '0;
        endcase
    endfunction

    function automatic logic signed [11:0] delta_y(input logic [2:0] d);
        unique case (d)
            3'd3, 3'd4, 3'd5: delta_y = ST;
            3'd7, 3'd0, 3'd1: delta_y = -ST;
            default:          delta_y = '0;
        endcase
    endfunction

    // Descending scan leaves the lowest free index in free_idx.
    always_comb begin
        free_ok  = '0;
        free_idx = '0;
        for (int t = 0; t < 2; t++) begin
            for (int i = 7; i >= 0; i--) begin
                if (!tab_q[t][i][0]) begin
                    free_ok[t]  = 1'b1;
                    free_idx[t] = 3'(i);
                end
            end
        end
    end

    assign sw_vld  = tab_q[k_q[3]][k_q[2:0]][0];
    assign sw_dir  = tab_q[k_q[3]][k_q[2:0]][3:1];
    assign sw_life = tab_q[k_q[3]][k_q[2:0]][8:4];
    assign sw_x    = tab_q[k_q[3]][k_q[2:0]][18:9];
    assign sw_y    = tab_q[k_q[3]][k_q[2:0]][28:19];

    assign nx = $signed({2'b00, sw_x}) + delta_x(sw_dir);
    assign ny = $signed({2'b00, sw_y}) + delta_y(sw_dir);

    assign retire = nx[11] || (nx >= LIM_W) || ny[11] || (ny >= LIM_H)
                  || (sw_life == 5'd1);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cd_d    = cd_q;
        pend_d  = pend_q;
        drop_d  = '0;
        ovr_d   = 1'b0;
        tab_d   = tab_q;
        unique case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_SWEEP;
                    k_d     = '0;
                    for (int t = 0; t < 2; t++) begin
                        if (cd_q[t] != '0) cd_d[t] = cd_q[t] - 8'd1;
                    end
                end
                // Service checks the pre-decrement cooldown; a spawn reloads it.
                for (int t = 0; t < 2; t++) begin
                    if (pend_q[t] && cd_q[t] == '0) begin
                        if (free_ok[t]) begin
                            tab_d[t][free_idx[t]] = {3'b000,
                                tank_y[t] + 10'd16, tank_x[t] + 10'd16,
                                LIFE5, turret_dir[t], 1'b1};
                            cd_d[t] = CD8;
                        end else begin
                            drop_d[t] = 1'b1;
                        end
                    end
                end
                pend_d = '0;
            end
            S_SWEEP: begin
                ovr_d = frame_tick;
                if (sw_vld) begin
                    if (retire) begin
                        tab_d[k_q[3]][k_q[2:0]][0] = 1'b0;
                    end else begin
                        tab_d[k_q[3]][k_q[2:0]][8:4]   = sw_life - 5'd1;
                        tab_d[k_q[3]][k_q[2:0]][18:9]  = nx[9:0];
                        tab_d[k_q[3]][k_q[2:0]][28:19] = ny[9:0];
                    end
                end
                k_d = k_q + 4'd1;
                if (k_q == 4'hF) state_d = S_IDLE;
            end
        endcase
        pend_d = pend_d | fire_req;
        // Applied last so a hit beats the sweep write on the same slot.
        if (hit_valid && tab_q[hit_tank][hit_idx][0]) begin
            tab_d[hit_tank][hit_idx][0] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cd_q    <= '0;
            pend_q  <= '0;
            drop_q  <= '0;
            ovr_q   <= 1'b0;
            tab_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cd_q    <= cd_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            ovr_q   <= ovr_d;
            tab_q   <= tab_d;
        end
    end

    assign bullet_array = tab_q;
    assign busy         = (state_q == S_SWEEP);
    assign fire_drop    = drop_q;
    assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Randomized scoreboard bench for bullet_scheduler against an
// event-level model of the bullet table, cooldowns and frame sweeps.
module tb_bullet_scheduler;

    localparam int STEP = 4;
    localparam int LIFE = 31;
    localparam int CDN  = 3;
    localparam int SW   = 640;
    localparam int SH   = 480;

    logic                  CLK = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  frame_tick = 1'b0;
    logic [1:0]            fire_req = '0;
    logic [1:0][9:0]       tank_x = '0;
    logic [1:0][9:0]       tank_y = '0;
    logic [1:0][2:0]       turret_dir = '0;
    logic                  hit_valid = 1'b0;
    logic                  hit_tank = 1'b0;
    logic [2:0]            hit_idx = '0;
    logic [1:0][7:0][31:0] bullet_array;
    logic                  busy;
    logic [1:0]            fire_drop;
    logic                  tick_overrun;

    bullet_scheduler #(
        .STEP(STEP), .LIFETIME(LIFE), .COOLDOWN(CDN),
        .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .CLK(CLK), .reset_n(reset_n), .frame_tick(frame_tick),
        .fire_req(fire_req), .tank_x(tank_x), .tank_y(tank_y),
        .turret_dir(turret_dir), .hit_valid(hit_valid),
        .hit_tank(hit_tank), .hit_idx(hit_idx),
        .bullet_array(bullet_array), .busy(busy),
        .fire_drop(fire_drop), .tick_overrun(tick_overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0][7:0][31:0] arr;
        logic                  bsy;
        logic [1:0]            drop;
        logic                  ovr;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model: plain per-bullet fields and a sweep start time.
    int m_v[2][8], m_d[2][8], m_l[2][8], m_x[2][8], m_y[2][8];
    int m_cd[2];
    bit m_pend[2];
    int sweep_at = -1000;
    int cyc = 0;
    int last_tick = -1000;
    int DXT[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int DYT[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    function automatic bit m_busy(int c);
        return (c > sweep_at) && (c <= sweep_at + 16);
    endfunction

    function automatic void m_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                m_v[r][i] = 0; m_d[r][i] = 0; m_l[r][i] = 0;
                m_x[r][i] = 0; m_y[r][i] = 0;
            end
            m_cd[r] = 0;
            m_pend[r] = 0;
        end
        sweep_at = -1000;
    endfunction

    function automatic exp_t m_pack(bit b, bit [1:0] dr, bit ov);
        exp_t e;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++)
                e.arr[r][i] = {3'b000, 10'(m_y[r][i]), 10'(m_x[r][i]),
                               5'(m_l[r][i]), 3'(m_d[r][i]), 1'(m_v[r][i])};
        e.bsy = b;
        e.drop = dr;
        e.ovr = ov;
        return e;
    endfunction

    function automatic bit row_full(int r);
        for (int i = 0; i < 8; i++) if (m_v[r][i] == 0) return 0;
        return 1;
    endfunction

    task automatic model_step();
        int ov[2][8];
        bit bc;
        bit [1:0] dr;
        bit [1:0] acc;
        bit ovr;
        int k, r, i, nx, ny, slot;
        ov = m_v;
        bc = m_busy(cyc);
        dr = '0;
        acc = '0;
        ovr = frame_tick && bc;
        if (!bc) begin
            for (int t = 0; t < 2; t++) begin
                if (m_pend[t]) begin
                    m_pend[t] = 0;
                    if (m_cd[t] == 0) begin
                        slot = -1;
                        for (int j = 0; j < 8; j++)
                            if (ov[t][j] == 0 && slot < 0) slot = j;
                        if (slot < 0) dr[t] = 1'b1;
                        else begin
                            m_v[t][slot] = 1;
                            m_d[t][slot] = int'(turret_dir[t]);
                            m_l[t][slot] = LIFE;
                            m_x[t][slot] = (int'(tank_x[t]) + 16) % 1024;
                            m_y[t][slot] = (int'(tank_y[t]) + 16) % 1024;
                            acc[t] = 1'b1;
                        end
                    end
                end
            end
            if (frame_tick) begin
                for (int t = 0; t < 2; t++) if (m_cd[t] > 0) m_cd[t]--;
                sweep_at = cyc;
            end
            for (int t = 0; t < 2; t++) if (acc[t]) m_cd[t] = CDN;
        end else begin
            k = cyc - sweep_at - 1;
            r = k / 8;
            i = k % 8;
            if (ov[r][i] != 0) begin
                nx = m_x[r][i] + STEP * DXT[m_d[r][i]];
                ny = m_y[r][i] + STEP * DYT[m_d[r][i]];
                if (nx < 0 || nx >= SW || ny < 0 || ny >= SH || m_l[r][i] == 1)
                    m_v[r][i] = 0;
                else begin
                    m_x[r][i] = nx;
                    m_y[r][i] = ny;
                    m_l[r][i] = m_l[r][i] - 1;
                end
            end
        end
        if (hit_valid && ov[hit_tank][hit_idx] != 0) m_v[hit_tank][hit_idx] = 0;
        for (int t = 0; t < 2; t++) if (fire_req[t]) m_pend[t] = 1;
        if (frame_tick) last_tick = cyc;
        cyc++;
        sbq.push_back(m_pack(m_busy(cyc), dr, ovr));
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
    endtask

    task automatic check_arr(string nm, logic [1:0][7:0][31:0] req);
        int br, bi;
        bit found;
        n_chk++;
        if (bullet_array === req) n_pass++;
        else begin
            br = 0; bi = 0; found = 0;
            for (int r = 0; r < 2; r++)
                for (int i = 0; i < 8; i++)
                    if (!found && bullet_array[r][i] !== req[r][i]) begin
                        found = 1; br = r; bi = i;
                    end
            $display("FAIL %s slot[%0d][%0d] act=%h req=%h t=%0t", nm, br, bi,
                     bullet_array[br][bi], req[br][bi], $time);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check_arr("table", e.arr);
                chk("busy", 64'(busy), 64'(e.bsy));
                chk("fire_drop", 64'(fire_drop), 64'(e.drop));
                chk("tick_overrun", 64'(tick_overrun), 64'(e.ovr));
            end
        end
    end

    task automatic idle_in();
        frame_tick = 1'b0;
        fire_req = '0;
        hit_valid = 1'b0;
    endtask

    task automatic step();
        model_step();
        @(negedge CLK);
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (18) step();
    endtask

    task automatic fire(logic [1:0] f);
        fire_req = f;
        step();
        fire_req = '0;
        step();
    endtask

    task automatic do_reset();
        idle_in();
        reset_n = 1'b0;
        sbq.delete();
        #1;
        check_arr("reset_table", '0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_drop", 64'(fire_drop), 64'd0);
        chk("reset_ovr", 64'(tick_overrun), 64'd0);
        m_reset();
        @(negedge CLK);
        reset_n = 1'b1;
    endtask

    initial begin
        int bcnt;
        m_reset();
        @(negedge CLK);
        do_reset();

        // Spawn from tank 0 at (100,200) heading right.
        tank_x[0] = 10'd100; tank_y[0] = 10'd200; turret_dir[0] = 3'd2;
        fire(2'b01);
        chk("spawn00", 64'(bullet_array[0][0]),
            64'({3'b0, 10'd216, 10'd116, 5'd31, 3'd2, 1'b1}));

        bcnt = 0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int j = 0; j < 18; j++) begin
            bcnt += int'(busy);
            step();
        end
        chk("busy_len", 64'(bcnt), 64'd16);
        chk("move00", 64'(bullet_array[0][0]),
            64'({3'b0, 10'd216, 10'd120, 5'd30, 3'd2, 1'b1}));

        // Asynchronous reset in the middle of a sweep.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (5) step();
        do_reset();

        // Both tanks fire in the same cycle.
        tank_x[1] = 10'd300; tank_y[1] = 10'd300; turret_dir[1] = 3'd0;
        fire(2'b11);
        chk("both_valid", 64'({bullet_array[1][0][0], bullet_array[0][0][0]}), 64'd3);
        chk("spawn10", 64'(bullet_array[1][0]),
            64'({3'b0, 10'd316, 10'd316, 5'd31, 3'd0, 1'b1}));

        // Up-left bullet spawned at x=2 (1010+16 truncates) retires next sweep.
        repeat (3) frame();
        tank_x[0] = 10'd1010; tank_y[0] = 10'd284; turret_dir[0] = 3'd7;
        fire(2'b01);
        chk("spawn01", 64'(bullet_array[0][1]),
            64'({3'b0, 10'd300, 10'd2, 5'd31, 3'd7, 1'b1}));
        frame();
        chk("retire01", 64'(bullet_array[0][1]),
            64'({3'b0, 10'd300, 10'd2, 5'd31, 3'd7, 1'b0}));

        // Fire tank 1 every frame until its row is full, then expect a drop.
        for (int n = 0; n < 40 && !row_full(1); n++) begin
            fire(2'b10);
            frame();
        end
        for (int n = 0; n < 6 && m_cd[1] != 0; n++) frame();
        chk("row1_full", 64'({bullet_array[1][7][0], bullet_array[1][6][0],
            bullet_array[1][5][0], bullet_array[1][4][0], bullet_array[1][3][0],
            bullet_array[1][2][0], bullet_array[1][1][0], bullet_array[1][0][0]}),
            64'hff);
        fire(2'b10);
        chk("drop_row1", 64'(fire_drop), 64'd2);

        // Overrun tick at t+5 and a hit on [1][3] in the cycle it is swept.
        hit_tank = 1'b1;
        hit_idx = 3'd3;
        for (int j = 0; j < 20; j++) begin
            frame_tick = (j == 0 || j == 5);
            hit_valid = (j == 12);
            step();
            if (j == 5) chk("overrun_pulse", 64'(tick_overrun), 64'd1);
        end
        idle_in();
        chk("hit13", 64'(bullet_array[1][3][0]), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            bit ft;
            if (!m_busy(cyc))
                ft = (cyc - last_tick >= 18) && ($urandom_range(0, 3) == 0);
            else
                ft = ($urandom_range(0, 29) == 0);
            if (!m_busy(cyc) && ((m_pend[0] && m_cd[0] == 0) ||
                                 (m_pend[1] && m_cd[1] == 0)))
                ft = 1'b0;
            frame_tick = ft;
            fire_req[0] = ($urandom_range(0, 5) == 0);
            fire_req[1] = ($urandom_range(0, 5) == 0);
            for (int t = 0; t < 2; t++) begin
                if ($urandom_range(0, 1) == 0) begin
                    tank_x[t] = 10'($urandom_range(0, 620));
                    tank_y[t] = 10'($urandom_range(0, 460));
                end else begin
                    tank_x[t] = 10'($urandom_range(0, 1023));
                    tank_y[t] = 10'($urandom_range(0, 1023));
                end
                turret_dir[t] = 3'($urandom_range(0, 7));
            end
            hit_valid = ($urandom_range(0, 7) == 0);
            hit_tank = 1'($urandom_range(0, 1));
            hit_idx = 3'($urandom_range(0, 7));
            step();
        end
        idle_in();
        repeat (20) step();
        @(posedge CLK);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
